// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundle of the fetch stage's control, instruction-memory and
//                IF/ID signals. The master modport is the fetch unit itself;
//                the slave modport is everything around it (hazard unit,
//                branch resolution, instruction memory, decode).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  // Control from hazard unit and branch/jump resolution
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;

  // Instruction memory port
  logic [31:0] pc_out;
  logic [31:0] instr_in;

  // IF/ID register and status
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] fetch_count;
  logic        fetch_fault;

  modport master (
    input  stall, branch_taken, branch_offset, jump, jump_target,
           jr, jr_target, instr_in,
    output pc_out, ifid_instr, ifid_pc_plus4, ifid_valid,
           fetch_count, fetch_fault
  );

  modport slave (
    output stall, branch_taken, branch_offset, jump, jump_target,
           jr, jr_target, instr_in,
    input  pc_out, ifid_instr, ifid_pc_plus4, ifid_valid,
           fetch_count, fetch_fault
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Program counter and fetch stage. Drives the instruction
//                memory PC, captures the returned word into IF/ID, handles
//                branch / jump / jump-register redirects, stall and flush,
//                and latches a sticky fault on any misaligned or
//                out-of-range PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_BITS = 10
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  // Any PC bit at or above ADDR_BITS set means the address is not backed
  // by instruction memory.
  localparam logic [31:0] c_HI_MASK = ~((32'd1 << ADDR_BITS) - 32'd1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc_plus4;
  logic        r_ifid_valid;
  logic [31:0] r_fetch_count;
  logic        r_fetch_fault;

  // --------------------------------------------------------------------------
  // Next-PC selection
  // --------------------------------------------------------------------------
  logic        w_redirect;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_redirect_target;
  logic [31:0] w_seq_pc;
  logic [31:0] w_next_pc;
  logic        w_load;
  logic        w_bad_pc;

  // Redirect inputs describe the instruction sitting in IF/ID, so they are
  // meaningless while IF/ID holds a bubble.
  assign w_redirect = r_ifid_valid & (bus.jr | bus.jump | bus.branch_taken);

  // Branch base is the branch's own PC+4; offset is in words.
  assign w_br_target = r_ifid_pc_plus4 +
                       {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};

  // Jump keeps the 256 MB region of the delay-slot address.
  assign w_j_target = {r_ifid_pc_plus4[31:28], bus.jump_target, 2'b00};

  // jr outranks jump, which outranks a taken branch.
  assign w_redirect_target = bus.jr   ? bus.jr_target :
                             bus.jump ? w_j_target    :
                                        w_br_target;

  assign w_seq_pc  = r_pc + 32'd4;
  assign w_next_pc = w_redirect ? w_redirect_target : w_seq_pc;

  // A PC load happens on a redirect (which beats stall) or on a normal
  // unstalled advance. Only a loaded PC is checked for faults.
  assign w_load = w_redirect | ~bus.stall;

  // Sequential overflow past the top of memory lands here as an
  // out-of-range address rather than wrapping to zero.
  assign w_bad_pc = (|w_next_pc[1:0]) | (|(w_next_pc & c_HI_MASK));

  // --------------------------------------------------------------------------
  // PC, IF/ID, counter and fault register update
  // --------------------------------------------------------------------------
  // Reset wins; a latched fault freezes the stage; otherwise load the next
  // PC and either flush IF/ID (redirect) or capture the fetched word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc            <= RESET_PC;
      r_ifid_instr    <= 32'd0;
      r_ifid_pc_plus4 <= 32'd0;
      r_ifid_valid    <= 1'b0;
      r_fetch_count   <= 32'd0;
      r_fetch_fault   <= 1'b0;
    end else if (!r_fetch_fault && w_load) begin
      if (w_bad_pc) begin
        // Keep the offending PC's predecessor visible for debug.
        r_fetch_fault <= 1'b1;
        r_ifid_valid  <= 1'b0;
      end else begin
        r_pc <= w_next_pc;
        if (w_redirect) begin
          // Squash the wrong-path word; pc_plus4 is left alone.
          r_ifid_instr <= 32'd0;
          r_ifid_valid <= 1'b0;
        end else begin
          r_ifid_instr    <= bus.instr_in;
          r_ifid_pc_plus4 <= w_seq_pc;
          r_ifid_valid    <= 1'b1;
          r_fetch_count   <= r_fetch_count + 32'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.pc_out        = r_pc;
  assign bus.ifid_instr    = r_ifid_instr;
  assign bus.ifid_pc_plus4 = r_ifid_pc_plus4;
  assign bus.ifid_valid    = r_ifid_valid;
  assign bus.fetch_count   = r_fetch_count;
  assign bus.fetch_fault   = r_fetch_fault;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch stage that drives the PC input of the instruction memory and captures the returned word into an IF/ID register for decode.
- Holds the architectural PC, computes the next PC (sequential, branch, jump, jump-register), and supports stall and flush.
- Flags fetch faults.
- Sits directly upstream of the instruction memory; feeds the decode/control stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_BITS, 10, number of byte-address bits backed by instruction memory (256 words → PC[9:2]); any PC with nonzero bits at or above ADDR_BITS is out of range.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID contents (hazard unit)
- branch_taken  in  1  branch resolved taken for instruction in IF/ID
- branch_offset  in  16  signed word offset (instr[15:0]) of that branch
- jump  in  1  j/jal in IF/ID
- jump_target  in  26  instr[25:0] of that jump
- jr  in  1  jr in IF/ID
- jr_target  in  32  register value for jr
- pc_out  out  32  current PC, drives instruction memory PC input
- instr_in  in  32  instruction word from instruction memory (combinational on pc_out)
- ifid_instr  out  32  registered instruction for decode
- ifid_pc_plus4  out  32  registered PC+4 of that instruction (jal link value, branch base)
- ifid_valid  out  1  IF/ID holds a real instruction
- fetch_count  out  32  number of instructions accepted into IF/ID
- fetch_fault  out  1  sticky fault flag

Behaviour:
- Reset (synchronous; clk edge with reset=1), regardless of any other input:
  - pc_out=RESET_PC, ifid_instr=0 (NOP), ifid_pc_plus4=0, ifid_valid=0, fetch_count=0, fetch_fault=0.
- Redirect target, computed from IF/ID contents (all 32-bit, wrap modulo 2^32):
  - Branch: ifid_pc_plus4 + (sign_extend(branch_offset) << 2).
  - Jump: {ifid_pc_plus4[31:28], jump_target, 2'b00}.
  - Jump-register: jr_target.
- Redirect qualification:
  - Redirect inputs are ignored when ifid_valid=0.
  - Priority: jr > jump > branch_taken > sequential (pc_out+4).
- Each clock edge (reset=0, fetch_fault=0), in priority order:
  1. Redirect active: pc_out←target; IF/ID flushed (ifid_valid←0, ifid_instr←0, ifid_pc_plus4 unchanged); fetch_count unchanged. Redirect overrides stall.
  2. Else stall=1: pc_out, all IF/ID outputs and fetch_count hold.
  3. Else: ifid_instr←instr_in, ifid_pc_plus4←pc_out+4, ifid_valid←1, fetch_count←fetch_count+1, pc_out←pc_out+4.
- Latency: the instruction at PC p appears on ifid_instr one edge after pc_out=p (no stall). Taken-redirect penalty is 1 bubble.
- Fault detection, evaluated on the PC value about to be loaded (sequential or redirect):
  - Fault if bits [1:0]≠0 or any bit [31:ADDR_BITS]≠0.
  - On fault: fetch_fault←1, pc_out holds old value, ifid_valid←0.
- Faulted state: while fetch_fault=1, pc_out and fetch_count hold, ifid_valid stays 0, all inputs are ignored. Only reset clears the fault.
- Sequential wrap: pc_out+4 crossing 2^ADDR_BITS counts as out of range and faults; it does not wrap.
- fetch_count wraps modulo 2^32.
- Reset asserted mid-stall or mid-redirect: reset wins on that edge.

Test Plan:
- Sequential fetch: reset, then 3 cycles with mem[0..2]=A,B,C → pc_out 0,4,8,C; ifid_instr A,B,C on successive edges; ifid_pc_plus4 4,8,C; fetch_count 3.
- Backward branch: IF/ID holds word at 0x30 (ifid_pc_plus4=0x34), branch_taken=1, offset=16'hFFF8 → next pc_out=0x14, ifid_valid=0 one cycle, then the word at 0x14 is latched.
- Jump and jr: jump_target=26'd20 → pc_out=0x50. Later jr=1 with jump=1, jr_target=0x60 → jr wins, pc_out=0x60. With ifid_valid=0 the same inputs are ignored (pc_out+4).
- Stall: stall=1 for 2 cycles at pc_out=0x10 → pc_out, ifid_* and fetch_count frozen. Release → resumes at 0x14.
- Fault: jr_target=0x62 → fetch_fault=1, pc_out stays unchanged, ifid_valid=0, fetch_count frozen over 5 further cycles. Also sequential from 0x3FC → fault.
- Reset mid-operation: assert reset while stall=1 and branch_taken=1 → all outputs return to reset values next edge, fetch_fault cleared.
